// File: rtl/if_id_elastic_if.sv
// Fetch-to-decode handshake bundle: one entry is an instruction word plus its sideband.
// The slave modport is the pipeline register; the master side is the fetch and decode pair around it.
interface if_id_elastic_if #(
  parameter int DATA_W = 32,
  parameter int SIDE_W = 1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [SIDE_W-1:0] in_side;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SIDE_W-1:0] out_side;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, in_side, out_ready,
    output in_ready, out_valid, out_data, out_side
  );

  modport master (
    output in_valid, in_data, in_side, out_ready,
    input  in_ready, out_valid, out_data, out_side
  );
endinterface

// File: rtl/if_id_elastic_reg.sv
// IF/ID boundary register with an elastic valid/ready handshake and a one-entry skid buffer.
// Adds stall, flush and bubble controls, and a saturating count of flushes since reset.
module if_id_elastic_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 SIDE_W    = 1,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  if_id_elastic_if.slave   bus,
  input  logic             stall,
  input  logic             flush,
  input  logic             bubble,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_cnt
);

  // The state encoding equals the number of entries held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] m_data;
  logic [SIDE_W-1:0] m_side;
  logic [DATA_W-1:0] s_data;
  logic [SIDE_W-1:0] s_side;

  logic              accept;
  logic              take;
  logic [DATA_W-1:0] in_data_q;
  logic [SIDE_W-1:0] in_side_q;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready depends on registered state only, and stall blocks the decode-side transfer.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = m_data;
  assign bus.out_side  = m_side;
  assign occupancy     = state;

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready & ~stall;

  // A bubbled entry still occupies a slot, but it carries a NOP.
  assign in_data_q = bubble ? NOP_VALUE : bus.in_data;
  assign in_side_q = bubble ? '0 : bus.in_side;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      m_data    <= NOP_VALUE;
      m_side    <= '0;
      s_data    <= NOP_VALUE;
      s_side    <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      m_data <= NOP_VALUE;
      m_side <= '0;
      s_data <= NOP_VALUE;
      s_side <= '0;
      if (flush_cnt != {CNT_W{1'b1}}) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            m_data <= in_data_q;
            m_side <= in_side_q;
          end
        end
        ONE: begin
          if (accept && take) begin
            m_data <= in_data_q;
            m_side <= in_side_q;
          end else if (accept) begin
            state  <= FULL;
            s_data <= in_data_q;
            s_side <= in_side_q;
          end else if (take) begin
            state  <= EMPTY;
            m_data <= NOP_VALUE;
            m_side <= '0;
          end
        end
        FULL: begin
          // The older skid entry moves up; a newer input can never overtake it.
          if (take) begin
            state  <= ONE;
            m_data <= s_data;
            m_side <= s_side;
            s_data <= NOP_VALUE;
            s_side <= '0;
          end
        end
        default: begin
          state  <= EMPTY;
          m_data <= NOP_VALUE;
          m_side <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_id_elastic_reg.md
Name: if_id_elastic_reg

Overview:
- Parametrised IF/ID pipeline boundary register.
- Successor of the fixed 32-bit IF/ID register. Adds a valid/ready elastic handshake, a one-entry skid buffer, separate stall, flush and bubble controls, and a saturating flush counter.
- Sits between instruction fetch and decode; each entry carries one instruction plus a sideband field (e.g. branch-predicted-taken).

Parameters:
- DATA_W, 32, instruction/payload width.
- SIDE_W, 1, sideband width (prediction bits etc.).
- NOP_VALUE, 0 (DATA_W bits), payload presented whenever no valid entry is at the output, and substituted on bubble.
- CNT_W, 8, width of the saturating flush counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an entry.
- in_data  in  DATA_W  fetched instruction.
- in_side  in  SIDE_W  fetch sideband.
- in_ready  out  1  stage can accept an entry this cycle.
- out_valid  out  1  decode-side entry valid.
- out_data  out  DATA_W  instruction to decode.
- out_side  out  SIDE_W  sideband to decode.
- out_ready  in  1  decode can consume.
- stall  in  1  hold contents regardless of out_ready.
- flush  in  1  kill all contents (mispredict/exception).
- bubble  in  1  squash the entry accepted this cycle into a NOP (jump redirect).
- occupancy  out  2  entries held: 0, 1 or 2.
- flush_cnt  out  CNT_W  number of flushes since reset, saturating.

Behaviour:
- Storage:
  - Main register M drives out_valid/out_data/out_side.
  - Skid register S holds an overflow entry.
- States: EMPTY (M, S invalid), ONE (M valid), FULL (M, S valid). occupancy = 0/1/2 respectively.
- Handshake terms:
  - in_ready = (state != FULL). It is a function of registered state only; no combinational path from out_ready/stall/flush.
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready & ~stall.
- Priority: reset > flush > stall/normal.
- Reset (async, takes effect immediately, also mid-operation):
  - state EMPTY; out_valid 0; out_data NOP_VALUE; out_side 0.
  - S cleared to NOP_VALUE/0; flush_cnt 0; in_ready 1.
- Flush (synchronous):
  - Next state EMPTY; out_data NOP_VALUE; out_side 0.
  - Any entry accepted in the same cycle is discarded.
  - bubble and stall are ignored.
  - flush_cnt += 1, saturating at all-ones.
- Bubble: applies only to an entry accepted in the same cycle. It is stored with data = NOP_VALUE and side = 0 but stays valid (occupies a slot). Bubble without accept has no effect.
- Transitions (no flush):
  - EMPTY: accept -> ONE, M <= in. Otherwise hold.
  - ONE:
    - accept & take -> ONE, M <= in.
    - accept & ~take -> FULL, S <= in.
    - ~accept & take -> EMPTY, M data <= NOP_VALUE, side <= 0.
    - Otherwise hold.
  - FULL: take -> ONE, M <= S, S cleared. Otherwise hold. No accept is possible in FULL.
- Stall: forces take = 0. Accept is still allowed while in_ready = 1, so a stalled ONE state fills to FULL.
- Timing: latency 1 cycle from accept to out_valid. Sustained throughput 1 entry/cycle when out_ready=1 and stall=0.
- Ordering: strict FIFO; S is never bypassed by a newer input.
- Invariants:
  - out_data == NOP_VALUE whenever out_valid == 0.
  - S is never valid while M is invalid.
- Unknown/illegal: none; all input combinations are defined.

Test Plan:
- Streaming: reset, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
- Backpressure/skid: hold out_ready=0 while sending 0xA1,0xA2 -> occupancy 2, in_ready 0, 0xA3 is not accepted. Raise out_ready -> outputs 0xA1 then 0xA2, then 0xA3 is accepted; order preserved.
- Stall vs ready: out_ready=1, stall=1 for 3 cycles with M=0x55 -> out_data held at 0x55, no take. Release stall -> 0x55 consumed next edge.
- Flush with simultaneous accept: state FULL (0xB1,0xB2), then flush=1 with in_valid=1 -> next cycle out_valid 0, out_data NOP_VALUE, occupancy 0, flush_cnt 1. Repeat 300 flushes with CNT_W=8 -> flush_cnt saturates at 255.
- Bubble: accept 0xC1 with in_side=1 and bubble=1 -> out_valid 1, out_data NOP_VALUE, out_side 0. A later 0xC2 without bubble passes unchanged.
- Async reset mid-operation: assert reset between edges while FULL -> outputs go to reset values immediately, before the next edge. Deassert -> in_ready 1 and normal acceptance resumes.
